// File: rtl/div_share_arb.sv
// Round-robin arbiter/sequencer sharing one pipelined signed divider between N_REQ requesters.
// Latency: grant is combinational; quotient returns to its requester DIV_LAT cycles after the handshake.
// Backpressure: none; one issue per cycle is always accepted and responses must be taken when strobed.
// Optional feature macro: DIV_SHARE_DIV0_FLAG_EN adds rsp_div0, flagging operations issued with div_b==0.
module div_share_arb #(
    parameter int N_REQ   = 4,
    parameter int A_W     = 9,
    parameter int B_W     = 9,
    parameter int O_W     = 12,
    parameter int DIV_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*A_W-1:0] req_a,
    input  logic [N_REQ*B_W-1:0] req_b,
    output logic [A_W-1:0]       div_a,
    output logic [B_W-1:0]       div_b,
    input  logic [O_W-1:0]       div_o,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [O_W-1:0]       rsp_o,
    output logic                 busy
`ifdef DIV_SHARE_DIV0_FLAG_EN
    ,
    output logic                 rsp_div0
`endif
);

    localparam int            ID_W    = $clog2(N_REQ);
    localparam logic [ID_W:0] N_REQ_W = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    logic [ID_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [DIV_LAT-1:0]           vld_q, vld_d;
    logic [DIV_LAT-1:0][ID_W-1:0] id_q, id_d;
`ifdef DIV_SHARE_DIV0_FLAG_EN
    logic [DIV_LAT-1:0]           z_q, z_d;
`endif

    logic            gnt_vld;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W:0]   cand;

    // Search from rr_ptr upward (wrapping) for the first valid requester.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W + 1)'(i);
            if (cand >= N_REQ_W) begin
                cand = cand - N_REQ_W;
            end
            if (!gnt_vld && req_valid[cand[ID_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = cand[ID_W-1:0];
            end
        end
    end

    // One-hot grant and operand mux to the divider; zeros when nobody is granted.
    always_comb begin
        req_ready = '0;
        div_a     = '0;
        div_b     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_vld && (gnt_id == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                div_a        = req_a[i*A_W +: A_W];
                div_b        = req_b[i*B_W +: B_W];
            end
        end
    end

    // Pointer moves just past the grantee on a handshake, otherwise holds.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            rr_ptr_d = (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);
        end
    end

    // Tag pipeline mirrors the divider: stage 0 takes this cycle's issue, all stages shift every cycle.
    always_comb begin
        vld_d    = '0;
        id_d     = '0;
        vld_d[0] = gnt_vld;
        id_d[0]  = gnt_id;
        for (int s = 1; s < DIV_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            id_d[s]  = id_q[s-1];
        end
    end

`ifdef DIV_SHARE_DIV0_FLAG_EN
    // Divide-by-zero flag travels alongside the tag so it lines up with the quotient.
    always_comb begin
        z_d    = '0;
        z_d[0] = gnt_vld && (div_b == '0);
        for (int s = 1; s < DIV_LAT; s++) begin
            z_d[s] = z_q[s-1];
        end
    end
`endif

    // State registers; reset drops every in-flight tag so no stale response can appear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            vld_q    <= '0;
            id_q     <= '0;
`ifdef DIV_SHARE_DIV0_FLAG_EN
            z_q      <= '0;
`endif
        end else begin
            rr_ptr_q <= rr_ptr_d;
            vld_q    <= vld_d;
            id_q     <= id_d;
`ifdef DIV_SHARE_DIV0_FLAG_EN
            z_q      <= z_d;
`endif
        end
    end

    // Route the divider output to the requester named by the last tag stage.
    always_comb begin
        rsp_valid = '0;
        if (vld_q[DIV_LAT-1]) begin
            rsp_valid[id_q[DIV_LAT-1]] = 1'b1;
        end
        rsp_o = (|rsp_valid) ? div_o : '0;
        busy  = |vld_q;
`ifdef DIV_SHARE_DIV0_FLAG_EN
        rsp_div0 = z_q[DIV_LAT-1] & vld_q[DIV_LAT-1];
`endif
    end

endmodule

// File: doc/div_share_arb.md
Name: div_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined signed fixed-point divider (o = a/b) between N_REQ requesters, e.g. the HOG block-normalisation lanes.
- Accepts at most one operand pair per cycle, drives it to the divider, and tracks each in-flight operation with a requester tag.
- Returns each quotient to its originating requester exactly DIV_LAT cycles after acceptance.
- The divider itself is instantiated outside this block.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- A_W, 9, dividend width (signed).
- B_W, 9, divisor width (signed).
- O_W, 12, quotient width (O_I_W+O_F_W of the divider).
- DIV_LAT, 1, divider latency in cycles from operand sample to valid o (1..8).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester grant (one-hot or zero).
- req_a  in  N_REQ*A_W  dividends, requester i at bits [i*A_W +: A_W].
- req_b  in  N_REQ*B_W  divisors, same packing.
- div_a  out  A_W  dividend to divider.
- div_b  out  B_W  divisor to divider.
- div_o  in  O_W  divider quotient.
- rsp_valid  out  N_REQ  one-hot response strobe.
- rsp_o  out  O_W  quotient for the strobed requester.
- busy  out  1  any operation in flight.

Behaviour:
- Reset:
  - rst is sampled on the clk edge only.
  - Sets rr_ptr=0 and clears all tag-pipeline valid bits.
  - After reset: rsp_valid=0, busy=0, req_ready=0 until a req_valid is seen; div_a=div_b=0 while idle.
  - Reset mid-operation drops all in-flight results; no rsp_valid may assert for operations accepted before reset.
- Arbitration (combinational from req_valid and rr_ptr):
  - Search requesters starting at index rr_ptr, ascending, wrapping modulo N_REQ.
  - The first one with req_valid=1 is granted: req_ready[g]=1, all other bits 0.
  - No req_valid set -> req_ready=0.
  - req_ready is independent of pipeline occupancy. The divider is fully pipelined, so one issue per cycle is always accepted; there is no backpressure.
- Handshake: transfer occurs on a clk edge where req_valid[g] & req_ready[g]. The requester holds a, b and valid until that edge, and may present a new pair the next cycle.
- Issue:
  - div_a/div_b = operands of granted requester (combinational mux), sampled by the divider on the same edge as the handshake.
  - No grant -> div_a=0, div_b=0.
- Pointer: on a handshake with grantee g, rr_ptr <= (g+1) mod N_REQ. With no handshake, rr_ptr holds.
- Tag pipeline:
  - DIV_LAT stages of {vld, id[clog2(N_REQ)-1:0]}.
  - Stage 0 loads {handshake, g}; it shifts every cycle unconditionally.
- Response:
  - rsp_valid = last-stage vld ? (1 << last-stage id) : 0.
  - rsp_o = div_o when rsp_valid != 0, else 0.
  - Latency: handshake at edge k -> rsp_valid high during the cycle after edge k+DIV_LAT-1, i.e. DIV_LAT cycles after acceptance.
  - Requesters must accept the response in that cycle.
- busy = OR of all stage vld bits.
- Arithmetic: no arithmetic is performed here. Quotient formatting and b=0 saturation belong to the divider: +max for a>=0, most-negative+1 for a<0.
- Simultaneous events:
  - A new issue and a response in the same cycle are legal and independent.
  - The same requester may be issued and responded to in the same cycle.
- rr_ptr wrap: grantee N_REQ-1 -> rr_ptr=0.

Optional Feature:
- Macro DIV_SHARE_DIV0_FLAG_EN.
- When defined:
  - Adds output rsp_div0 (1 bit).
  - Tag pipeline carries an extra bit loaded with (div_b==0) at issue.
  - rsp_div0 = last-stage bit & last-stage vld, aligned with rsp_valid. Reset value 0.
- When undefined: no port and no extra tag bit; behaviour otherwise identical.

Test Plan:
- Basic issue: rst released, req_valid=0001, a0=3, b0=2, DIV_LAT=1 -> req_ready=0001 the same cycle; next cycle rsp_valid=0001, rsp_o=0x180; busy high for exactly 1 cycle.
- Contention: req_valid=1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rsp_valid follows the same order 1 cycle later, with no gaps.
- Wrap: after a grant to 3 (rr_ptr=0), req_valid=0110 -> grant 1, then 2, then 1.
- Reset mid-flight: DIV_LAT=3, handshake requester 2 at cycle 0, rst=1 at cycle 1 -> rsp_valid stays 0 through cycle 5; busy=0 from the cycle after the rst edge; rr_ptr=0.
- Divide by zero (macro defined): requester 1 with a=5, b=0 -> rsp_valid=0010, rsp_o=0x7FF, rsp_div0=1. Then a=-5, b=0 -> rsp_o=0x801, rsp_div0=1. Then a=4, b=2 -> rsp_div0=0.
- Back-to-back same requester: req_valid=0001 for 4 cycles with a=1,2,3,4, b=1 -> 4 consecutive responses 0x100, 0x200, 0x300, 0x400 in order.
